bit_serial_adder: RTL and testbench

//   Sequential WIDTH-bit adder that computes one bit per clock, LSB first.

---
 rtl/bit_serial_adder.sv | 162 ++++++++++++++++
 tb/tb_bit_serial_adder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_adder.sv
// Purpose: WIDTH-bit adder computing one sum bit per clock, LSB first, using a carry flip-flop between bits.
// Latency: start accepted at edge T -> done pulses in the cycle after edge T+WIDTH; next start accepted at edge T+WIDTH+2.
// Backpressure: none; start is a request honoured only while idle (busy=0); requests while busy are dropped, not queued.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  begin an add, sampling a/b (ignored while busy)
//   a, b   WIDTH-bit operands
//   busy   high while an add is running or its result is being announced
//   done   one-cycle pulse when s/co take a new result
//   s, co  registered sum (mod 2^WIDTH) and carry out; hold until the next result

// Half adder cell: two of these plus an OR form the per-bit full adder.
module bit_serial_adder_ha (
    input  logic x_i,
    input  logic y_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = x_i ^ y_i;
    assign c_o = x_i & y_i;
endmodule

module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = (WIDTH > 1) ? WIDTH - 1 : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [RW-1:0]    rsum_q, rsum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;

    // Per-bit full adder: HA1 on the operand bits, HA2 folds in the carry.
    logic p, g1, sb, g2, carry_nxt;

    bit_serial_adder_ha u_ha1 (
        .x_i (ra_q[0]),
        .y_i (rb_q[0]),
        .s_o (p),
        .c_o (g1)
    );

    bit_serial_adder_ha u_ha2 (
        .x_i (p),
        .y_i (carry_q),
        .s_o (sb),
        .c_o (g2)
    );

    assign carry_nxt = g1 | g2;

    // The sum shift register only needs WIDTH-1 bits: on the final RUN cycle
    // the last sum bit goes straight into s together with the stored bits,
    // so the oldest stored bit drops out of the register as it reaches s.
    logic [WIDTH-1:0] sum_full;
    logic [RW-1:0]    rsum_shift;

    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_full   = sb;
            assign rsum_shift = 1'b0;
        end else begin : g_wn
            assign sum_full   = {sb, rsum_q};
            assign rsum_shift = sum_full[WIDTH-1:1];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rsum_d  = rsum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        co_d    = co_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    rsum_d  = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = carry_nxt;
                rsum_d  = rsum_shift;
                ra_d    = ra_q >> 1;
                rb_d    = rb_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // Result registers change only here, so partial sums never reach the ports.
                    s_d     = sum_full;
                    co_d    = carry_nxt;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rsum_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rsum_q  <= rsum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            co_q    <= co_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign co   = co_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Purpose: self-checking bench for bit_serial_adder; randomized and directed adds
// against an a+b reference with a busy-window model, checked by a scoreboard monitor.
// Drives inputs 1 time unit after the rising edge, samples outputs on the falling edge.
module tb_bit_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, co;
    logic [W-1:0] s;

    // Second instance for the single-bit boundary case.
    logic start1 = 1'b0;
    logic a1 = 1'b0;
    logic b1 = 1'b0;
    logic busy1, done1, s1, co1;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
    );

    bit_serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .s     (s1),
        .co    (co1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
    } res_t;

    res_t         exp_q[$];
    logic [W-1:0] exp_s  = '0;
    logic         exp_co = 1'b0;
    int           m_cnt  = 0;   // cycles left in the model's busy window
    int           m_acc  = 0;   // adds accepted by the model
    bit           mon_en = 1'b0;
    int           checks = 0;
    int           errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an idle adder accepts start, the result is a+b, and the
    // adder stays busy for W RUN cycles plus one DONE cycle.
    initial begin : model
        res_t r;
        forever begin
            @(posedge clk);
            if (rst_n) begin
                if (m_cnt == 0) begin
                    if (start === 1'b1) begin
                        {r.co, r.s} = {1'b0, a} + {1'b0, b};
                        exp_q.push_back(r);
                        m_cnt = W + 1;
                        m_acc++;
                    end
                end else begin
                    m_cnt--;
                end
            end
        end
    end

    // Monitor: pops a result whenever the DUT announces one; s/co are compared
    // every cycle against the last announced result, covering stability too.
    initial begin : monitor
        res_t r;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                check("busy", busy, m_cnt != 0);
                check("done", done, m_cnt == 1);
                if (done === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL spurious_done: got done=1 expected no pending add at %0t", $time);
                    end else begin
                        r      = exp_q.pop_front();
                        exp_s  = r.s;
                        exp_co = r.co;
                    end
                end
                check("s", s, exp_s);
                check("co", co, exp_co);
            end
        end
    end

    task automatic drive(input logic st, input logic [W-1:0] aa, input logic [W-1:0] bb);
        @(posedge clk);
        #1;
        start = st;
        a     = aa;
        b     = bb;
    endtask

    task automatic settle();
        repeat (W + 3) drive(1'b0, W'($urandom), W'($urandom));
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2;
        rst_n  = 1'b0;
        m_cnt  = 0;
        exp_q.delete();
        exp_s  = '0;
        exp_co = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_s", s, 0);
        check("rst_co", co, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_w1();
        logic [1:0] v;
        int         sum;
        for (int i = 0; i < 4; i++) begin
            v   = 2'(i);
            sum = int'(v[1]) + int'(v[0]);
            @(posedge clk);
            #1;
            start1 = 1'b1;
            a1     = v[1];
            b1     = v[0];
            @(posedge clk);
            #1;
            start1 = 1'b0;
            @(negedge clk);
            check("w1_run_busy", busy1, 1);
            check("w1_run_done", done1, 0);
            @(negedge clk);
            check("w1_done", done1, 1);
            check("w1_s", s1, sum % 2);
            check("w1_co", co1, sum / 2);
        end
    endtask

    initial begin : stim
        int cyc;
        int target;
        int n;

        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Basic add, then overflow and zero cases.
        drive(1'b1, 8'h3C, 8'h0F); settle();
        drive(1'b1, 8'hFF, 8'h01); settle();
        drive(1'b1, 8'hFF, 8'hFF); settle();
        drive(1'b1, 8'h00, 8'h00); settle();

        // Starts during RUN and during the done cycle are dropped; the one right after is taken.
        drive(1'b1, 8'h12, 8'h34);
        for (int k = 1; k <= W + 2; k++) begin
            if (k == W + 2) drive(1'b1, 8'h05, 8'h07);
            else            drive((k == 3) || (k == W + 1), 8'hAA, 8'hAA);
        end
        settle();

        // Asynchronous reset while idle, then abort mid-add and restart.
        async_reset();
        drive(1'b1, 8'hF0, 8'h0F);
        repeat (3) drive(1'b0, W'($urandom), W'($urandom));
        async_reset();
        drive(1'b1, 8'h01, 8'h01); settle();

        // start held high: a new add every W+2 cycles.
        repeat (3 * (W + 2)) drive(1'b1, W'($urandom), W'($urandom));
        settle();

        test_w1();

        // Random regression with random gaps and stray starts.
        cyc    = 0;
        target = m_acc + 1000;
        while (m_acc < target && cyc < 60000) begin
            drive(1'b1, W'($urandom), W'($urandom));
            cyc++;
            n = $urandom_range(0, W + 6);
            repeat (n) begin
                drive($urandom_range(0, 3) == 0, W'($urandom), W'($urandom));
                cyc++;
            end
        end
        drive(1'b0, '0, '0);
        settle();

        checks++;
        if (m_acc < target) begin
            errors++;
            $display("FAIL random_budget: got %0d adds expected %0d", m_acc, target);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_done: got %0d pending results expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
